sys_ctrl_rx_cmd: RTL and testbench

Command sequencer between the UART RX byte stream and the register file (RF) and ALU datapath. It parses multi-byte host frames and issues RF write/read strobes and ALU enable/function. It drives the ALU clock-gate enable. It returns RF read data and ALU results on the sender interfaces that the TX controller consumes.

---
 rtl/sys_ctrl_rx_cmd_if.sv | 39 +++
 rtl/sys_ctrl_rx_cmd.sv | 192 +++++++++++++++++++
 tb/tb_sys_ctrl_rx_cmd.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_rx_cmd_if.sv
// rtl/sys_ctrl_rx_cmd_if.sv - UART RX / RF / ALU / TX-sender signal bundle for sys_ctrl_rx_cmd
interface sys_ctrl_rx_cmd_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4,
    parameter int FUN_W = 4
);
    logic [WIDTH-1:0]   RX_P_DATA;
    logic               RX_D_VLD;
    logic [WIDTH-1:0]   RF_RdData;
    logic               RF_RdData_VLD;
    logic [2*WIDTH-1:0] ALU_OUT;
    logic               ALU_OUT_VLD;
    logic [ADDR-1:0]    RF_Address;
    logic               RF_WrEn;
    logic [WIDTH-1:0]   RF_WrData;
    logic               RF_RdEn;
    logic               ALU_EN;
    logic [FUN_W-1:0]   ALU_FUN;
    logic               CLK_GATE_EN;
    logic [WIDTH-1:0]   UART_RF_SENDER_DATA;
    logic               UART_RF_SENDER_VALID;
    logic [2*WIDTH-1:0] UART_ALU_SENDER_DATA;
    logic               UART_ALU_SENDER_VALID;
    logic               CMD_ERR;

    // master: the command sequencer; slave: the surrounding UART/RF/ALU/TX system
    modport master (
        input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_VLD, ALU_OUT, ALU_OUT_VLD,
        output RF_Address, RF_WrEn, RF_WrData, RF_RdEn, ALU_EN, ALU_FUN, CLK_GATE_EN,
               UART_RF_SENDER_DATA, UART_RF_SENDER_VALID,
               UART_ALU_SENDER_DATA, UART_ALU_SENDER_VALID, CMD_ERR
    );
    modport slave (
        output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_VLD, ALU_OUT, ALU_OUT_VLD,
        input  RF_Address, RF_WrEn, RF_WrData, RF_RdEn, ALU_EN, ALU_FUN, CLK_GATE_EN,
               UART_RF_SENDER_DATA, UART_RF_SENDER_VALID,
               UART_ALU_SENDER_DATA, UART_ALU_SENDER_VALID, CMD_ERR
    );
endinterface

// File: rtl/sys_ctrl_rx_cmd.sv
// rtl/sys_ctrl_rx_cmd.sv - UART RX frame parser driving RF/ALU strobes and TX sender results
// Optional inter-byte timeout abort enabled by defining SYS_CTRL_TIMEOUT_EN.
module sys_ctrl_rx_cmd #(
    parameter int WIDTH          = 8,
    parameter int ADDR           = 4,
    parameter int FUN_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    sys_ctrl_rx_cmd_if.master     bus
);
    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT
    } state_t;

    state_t              state, state_nx;
    logic [ADDR-1:0]     wr_addr_q, wr_addr_nx;
    logic                timeout;

    logic [ADDR-1:0]     rf_address_nx;
    logic                rf_wren_nx, rf_rden_nx, alu_en_nx, gate_nx, cmd_err_nx;
    logic [WIDTH-1:0]    rf_wrdata_nx, rf_snd_data_nx;
    logic [FUN_W-1:0]    alu_fun_nx;
    logic                rf_snd_vld_nx, alu_snd_vld_nx;
    logic [2*WIDTH-1:0]  alu_snd_data_nx;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             accepted;

    // Stray bytes in the wait states are dropped, so they do not restart the timeout
    always_comb begin
        accepted = 1'b0;
        case (state)
            IDLE:     accepted = 1'b0;
            RD_WAIT:  accepted = bus.RF_RdData_VLD;
            ALU_WAIT: accepted = bus.ALU_OUT_VLD;
            default:  accepted = bus.RX_D_VLD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            to_cnt <= '0;
        else if (state == IDLE || accepted)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (state != IDLE) && !accepted && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state                     <= IDLE;
            wr_addr_q                 <= '0;
            bus.RF_Address            <= '0;
            bus.RF_WrEn               <= 1'b0;
            bus.RF_WrData             <= '0;
            bus.RF_RdEn               <= 1'b0;
            bus.ALU_EN                <= 1'b0;
            bus.ALU_FUN               <= '0;
            bus.CLK_GATE_EN           <= 1'b0;
            bus.UART_RF_SENDER_DATA   <= '0;
            bus.UART_RF_SENDER_VALID  <= 1'b0;
            bus.UART_ALU_SENDER_DATA  <= '0;
            bus.UART_ALU_SENDER_VALID <= 1'b0;
            bus.CMD_ERR               <= 1'b0;
        end else begin
            state                     <= state_nx;
            wr_addr_q                 <= wr_addr_nx;
            bus.RF_Address            <= rf_address_nx;
            bus.RF_WrEn               <= rf_wren_nx;
            bus.RF_WrData             <= rf_wrdata_nx;
            bus.RF_RdEn               <= rf_rden_nx;
            bus.ALU_EN                <= alu_en_nx;
            bus.ALU_FUN               <= alu_fun_nx;
            bus.CLK_GATE_EN           <= gate_nx;
            bus.UART_RF_SENDER_DATA   <= rf_snd_data_nx;
            bus.UART_RF_SENDER_VALID  <= rf_snd_vld_nx;
            bus.UART_ALU_SENDER_DATA  <= alu_snd_data_nx;
            bus.UART_ALU_SENDER_VALID <= alu_snd_vld_nx;
            bus.CMD_ERR               <= cmd_err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (timeout)
            state_nx = IDLE;
        else case (state)
            IDLE: if (bus.RX_D_VLD) begin
                case (bus.RX_P_DATA)
                    8'hAA:   state_nx = WR_ADDR;
                    8'hBB:   state_nx = RD_ADDR;
                    8'hCC:   state_nx = ALU_A;
                    8'hDD:   state_nx = ALU_FUN;
                    default: state_nx = IDLE;
                endcase
            end
            WR_ADDR:  if (bus.RX_D_VLD) state_nx = WR_DATA;
            WR_DATA:  if (bus.RX_D_VLD) state_nx = IDLE;
            RD_ADDR:  if (bus.RX_D_VLD) state_nx = RD_WAIT;
            RD_WAIT:  if (bus.RF_RdData_VLD) state_nx = IDLE;
            ALU_A:    if (bus.RX_D_VLD) state_nx = ALU_B;
            ALU_B:    if (bus.RX_D_VLD) state_nx = ALU_FUN;
            ALU_FUN:  if (bus.RX_D_VLD) state_nx = ALU_WAIT;
            ALU_WAIT: if (bus.ALU_OUT_VLD) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Clock gate opens on the byte that enters ALU_FUN so it leads ALU_EN by at least one cycle
    always_comb begin
        wr_addr_nx      = wr_addr_q;
        rf_address_nx   = bus.RF_Address;
        rf_wrdata_nx    = bus.RF_WrData;
        alu_fun_nx      = bus.ALU_FUN;
        gate_nx         = bus.CLK_GATE_EN;
        rf_snd_data_nx  = bus.UART_RF_SENDER_DATA;
        alu_snd_data_nx = bus.UART_ALU_SENDER_DATA;
        rf_wren_nx      = 1'b0;
        rf_rden_nx      = 1'b0;
        alu_en_nx       = 1'b0;
        rf_snd_vld_nx   = 1'b0;
        alu_snd_vld_nx  = 1'b0;
        cmd_err_nx      = 1'b0;
        if (timeout) begin
            cmd_err_nx = 1'b1;
            gate_nx    = 1'b0;
        end else case (state)
            IDLE: if (bus.RX_D_VLD) begin
                case (bus.RX_P_DATA)
                    8'hAA, 8'hBB, 8'hCC: cmd_err_nx = 1'b0;
                    8'hDD:               gate_nx    = 1'b1;
                    default:             cmd_err_nx = 1'b1;
                endcase
            end
            WR_ADDR: if (bus.RX_D_VLD) wr_addr_nx = bus.RX_P_DATA[ADDR-1:0];
            WR_DATA: if (bus.RX_D_VLD) begin
                rf_wren_nx    = 1'b1;
                rf_address_nx = wr_addr_q;
                rf_wrdata_nx  = bus.RX_P_DATA;
            end
            RD_ADDR: if (bus.RX_D_VLD) begin
                rf_rden_nx    = 1'b1;
                rf_address_nx = bus.RX_P_DATA[ADDR-1:0];
            end
            RD_WAIT: begin
                cmd_err_nx = bus.RX_D_VLD;
                if (bus.RF_RdData_VLD) begin
                    rf_snd_vld_nx  = 1'b1;
                    rf_snd_data_nx = bus.RF_RdData;
                end
            end
            ALU_A: if (bus.RX_D_VLD) begin
                rf_wren_nx    = 1'b1;
                rf_address_nx = ADDR'(0);
                rf_wrdata_nx  = bus.RX_P_DATA;
            end
            ALU_B: if (bus.RX_D_VLD) begin
                rf_wren_nx    = 1'b1;
                rf_address_nx = ADDR'(1);
                rf_wrdata_nx  = bus.RX_P_DATA;
                gate_nx       = 1'b1;
            end
            ALU_FUN: begin
                gate_nx = 1'b1;
                if (bus.RX_D_VLD) begin
                    alu_en_nx  = 1'b1;
                    alu_fun_nx = bus.RX_P_DATA[FUN_W-1:0];
                end
            end
            ALU_WAIT: begin
                cmd_err_nx = bus.RX_D_VLD;
                if (bus.ALU_OUT_VLD) begin
                    alu_snd_vld_nx  = 1'b1;
                    alu_snd_data_nx = bus.ALU_OUT;
                    gate_nx         = 1'b0;
                end
            end
            default: cmd_err_nx = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_sys_ctrl_rx_cmd.sv
// tb/tb_sys_ctrl_rx_cmd.sv - directed self-checking bench for sys_ctrl_rx_cmd
module tb_sys_ctrl_rx_cmd;
    localparam int TIMEOUT_CYCLES = 1024;

    logic CLK;
    logic RST;
    int   total_n;
    int   pass_n;
    int   wren_n, rden_n, aen_n, err_n, rsv_n, asv_n;
    logic [46:0] outs;

    sys_ctrl_rx_cmd_if bus ();

    sys_ctrl_rx_cmd #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    assign outs = {bus.RF_Address, bus.RF_WrEn, bus.RF_WrData, bus.RF_RdEn, bus.ALU_EN,
                   bus.ALU_FUN, bus.CLK_GATE_EN, bus.UART_RF_SENDER_DATA,
                   bus.UART_RF_SENDER_VALID, bus.UART_ALU_SENDER_DATA,
                   bus.UART_ALU_SENDER_VALID, bus.CMD_ERR};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Pulse counters sampled mid-cycle, one sample per clock
    always @(negedge CLK) begin
        if (bus.RF_WrEn)               wren_n++;
        if (bus.RF_RdEn)               rden_n++;
        if (bus.ALU_EN)                aen_n++;
        if (bus.CMD_ERR)               err_n++;
        if (bus.UART_RF_SENDER_VALID)  rsv_n++;
        if (bus.UART_ALU_SENDER_VALID) asv_n++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(negedge CLK);
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        @(negedge CLK);
        bus.RF_RdData     = d;
        bus.RF_RdData_VLD = 1'b1;
        @(negedge CLK);
        bus.RF_RdData_VLD = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] d);
        @(negedge CLK);
        bus.ALU_OUT     = d;
        bus.ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        bus.ALU_OUT_VLD = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        bus.RX_P_DATA = '0; bus.RX_D_VLD = 1'b0;
        bus.RF_RdData = '0; bus.RF_RdData_VLD = 1'b0;
        bus.ALU_OUT = '0;   bus.ALU_OUT_VLD = 1'b0;
        repeat (3) @(negedge CLK);
        total_n++;
        if (outs !== 47'd0) $display("FAIL reset_outputs: got %h expected 0", outs);
        else pass_n++;
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_rf_write;
        int w0, e0, r0, a0;
        w0 = wren_n; e0 = err_n; r0 = rsv_n; a0 = asv_n;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        total_n++;
        if ({bus.RF_WrEn, bus.RF_Address, bus.RF_WrData} !== {1'b1, 4'h5, 8'h3C})
            $display("FAIL wr_strobe: got %b/%h/%h expected 1/5/3c", bus.RF_WrEn, bus.RF_Address, bus.RF_WrData);
        else pass_n++;
        @(negedge CLK);
        total_n++;
        if ({bus.RF_WrEn, bus.RF_Address, bus.RF_WrData} !== {1'b0, 4'h5, 8'h3C})
            $display("FAIL wr_one_cycle_hold: got %b/%h/%h expected 0/5/3c", bus.RF_WrEn, bus.RF_Address, bus.RF_WrData);
        else pass_n++;
        total_n++;
        if ({wren_n - w0, err_n - e0, rsv_n - r0, asv_n - a0} !== {32'd1, 32'd0, 32'd0, 32'd0})
            $display("FAIL wr_pulse_counts: got wr=%0d err=%0d rsv=%0d asv=%0d expected 1/0/0/0", wren_n - w0, err_n - e0, rsv_n - r0, asv_n - a0);
        else pass_n++;
    endtask

    task automatic test_rf_read;
        int r0;
        r0 = rden_n;
        send_byte(8'hBB); send_byte(8'h15);
        total_n++;
        if ({bus.RF_RdEn, bus.RF_Address} !== {1'b1, 4'h5})
            $display("FAIL rd_strobe: got %b/%h expected 1/5", bus.RF_RdEn, bus.RF_Address);
        else pass_n++;
        repeat (2) @(negedge CLK);
        pulse_rd(8'h3C);
        total_n++;
        if ({bus.UART_RF_SENDER_VALID, bus.UART_RF_SENDER_DATA} !== {1'b1, 8'h3C})
            $display("FAIL rf_sender: got %b/%h expected 1/3c", bus.UART_RF_SENDER_VALID, bus.UART_RF_SENDER_DATA);
        else pass_n++;
        @(negedge CLK);
        total_n++;
        if ({bus.UART_RF_SENDER_VALID, bus.UART_RF_SENDER_DATA, rden_n - r0} !== {1'b0, 8'h3C, 32'd1})
            $display("FAIL rf_sender_hold: got %b/%h rden=%0d expected 0/3c/1", bus.UART_RF_SENDER_VALID, bus.UART_RF_SENDER_DATA, rden_n - r0);
        else pass_n++;
    endtask

    task automatic test_alu_operands;
        int a0;
        a0 = aen_n;
        send_byte(8'hCC); send_byte(8'h12);
        total_n++;
        if ({bus.RF_WrEn, bus.RF_Address, bus.RF_WrData} !== {1'b1, 4'h0, 8'h12})
            $display("FAIL alu_wr_a: got %b/%h/%h expected 1/0/12", bus.RF_WrEn, bus.RF_Address, bus.RF_WrData);
        else pass_n++;
        send_byte(8'h34);
        total_n++;
        if ({bus.RF_WrEn, bus.RF_Address, bus.RF_WrData} !== {1'b1, 4'h1, 8'h34})
            $display("FAIL alu_wr_b: got %b/%h/%h expected 1/1/34", bus.RF_WrEn, bus.RF_Address, bus.RF_WrData);
        else pass_n++;
        @(negedge CLK);
        total_n++;
        if ({bus.CLK_GATE_EN, aen_n - a0} !== {1'b1, 32'd0})
            $display("FAIL gate_before_en: got gate=%b alu_en_count=%0d expected 1/0", bus.CLK_GATE_EN, aen_n - a0);
        else pass_n++;
        send_byte(8'h01);
        total_n++;
        if ({bus.ALU_EN, bus.ALU_FUN, bus.CLK_GATE_EN} !== {1'b1, 4'h1, 1'b1})
            $display("FAIL alu_en_fun1: got %b/%h/%b expected 1/1/1", bus.ALU_EN, bus.ALU_FUN, bus.CLK_GATE_EN);
        else pass_n++;
        pulse_alu(16'h0046);
        total_n++;
        if ({bus.UART_ALU_SENDER_VALID, bus.UART_ALU_SENDER_DATA, bus.CLK_GATE_EN} !== {1'b1, 16'h0046, 1'b0})
            $display("FAIL alu_sender: got %b/%h gate=%b expected 1/0046/0", bus.UART_ALU_SENDER_VALID, bus.UART_ALU_SENDER_DATA, bus.CLK_GATE_EN);
        else pass_n++;
        @(negedge CLK);
        total_n++;
        if ({bus.UART_ALU_SENDER_VALID, bus.ALU_EN} !== 2'b00)
            $display("FAIL alu_sender_one_cycle: got valid=%b en=%b expected 0/0", bus.UART_ALU_SENDER_VALID, bus.ALU_EN);
        else pass_n++;
    endtask

    task automatic test_alu_no_operands;
        int s0, w0;
        s0 = asv_n;
        pulse_alu(16'hBEEF);
        @(negedge CLK);
        total_n++;
        if ({asv_n - s0, bus.UART_ALU_SENDER_DATA} !== {32'd0, 16'h0046})
            $display("FAIL stray_alu_vld: got count=%0d data=%h expected 0/0046", asv_n - s0, bus.UART_ALU_SENDER_DATA);
        else pass_n++;
        w0 = wren_n;
        send_byte(8'hDD); send_byte(8'h02);
        total_n++;
        if ({bus.ALU_EN, bus.ALU_FUN, wren_n - w0} !== {1'b1, 4'h2, 32'd0})
            $display("FAIL alu_dd: got en=%b fun=%h wr_count=%0d expected 1/2/0", bus.ALU_EN, bus.ALU_FUN, wren_n - w0);
        else pass_n++;
        pulse_alu(16'h0102);
        total_n++;
        if ({bus.UART_ALU_SENDER_VALID, bus.UART_ALU_SENDER_DATA} !== {1'b1, 16'h0102})
            $display("FAIL alu_dd_sender: got %b/%h expected 1/0102", bus.UART_ALU_SENDER_VALID, bus.UART_ALU_SENDER_DATA);
        else pass_n++;
    endtask

    task automatic test_bad_cmd;
        send_byte(8'h55);
        total_n++;
        if (bus.CMD_ERR !== 1'b1) $display("FAIL bad_cmd_err: got %b expected 1", bus.CMD_ERR);
        else pass_n++;
        @(negedge CLK);
        total_n++;
        if (bus.CMD_ERR !== 1'b0) $display("FAIL bad_cmd_err_one_cycle: got %b expected 0", bus.CMD_ERR);
        else pass_n++;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
        total_n++;
        if ({bus.RF_WrEn, bus.RF_Address, bus.RF_WrData} !== {1'b1, 4'h1, 8'hFF})
            $display("FAIL wr_after_err: got %b/%h/%h expected 1/1/ff", bus.RF_WrEn, bus.RF_Address, bus.RF_WrData);
        else pass_n++;
        send_byte(8'hDD); send_byte(8'h03); send_byte(8'h77);
        total_n++;
        if ({bus.CMD_ERR, bus.ALU_EN} !== 2'b10)
            $display("FAIL byte_in_alu_wait: got err=%b en=%b expected 1/0", bus.CMD_ERR, bus.ALU_EN);
        else pass_n++;
        pulse_alu(16'h0003);
        total_n++;
        if ({bus.UART_ALU_SENDER_VALID, bus.UART_ALU_SENDER_DATA} !== {1'b1, 16'h0003})
            $display("FAIL alu_wait_survives_stray: got %b/%h expected 1/0003", bus.UART_ALU_SENDER_VALID, bus.UART_ALU_SENDER_DATA);
        else pass_n++;
    endtask

    task automatic test_reset_mid_frame;
        int w0;
        send_byte(8'hAA); send_byte(8'h05);
        w0 = wren_n;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total_n++;
        if (outs !== 47'd0) $display("FAIL mid_frame_reset: got %h expected 0", outs);
        else pass_n++;
        @(negedge CLK);
        RST = 1'b1;
        send_byte(8'h3C);
        total_n++;
        if (bus.CMD_ERR !== 1'b1) $display("FAIL post_reset_decode: got err=%b expected 1", bus.CMD_ERR);
        else pass_n++;
        @(negedge CLK);
        total_n++;
        if (wren_n - w0 !== 0) $display("FAIL post_reset_no_write: got %0d writes expected 0", wren_n - w0);
        else pass_n++;
    endtask

`ifdef SYS_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        int w0;
        w0 = wren_n;
        send_byte(8'hAA);
        repeat (TIMEOUT_CYCLES - 1) @(negedge CLK);
        total_n++;
        if (bus.CMD_ERR !== 1'b0) $display("FAIL timeout_early: got %b expected 0", bus.CMD_ERR);
        else pass_n++;
        @(negedge CLK);
        total_n++;
        if ({bus.CMD_ERR, bus.CLK_GATE_EN} !== 2'b10)
            $display("FAIL timeout_abort: got err=%b gate=%b expected 1/0", bus.CMD_ERR, bus.CLK_GATE_EN);
        else pass_n++;
        send_byte(8'h3C);
        @(negedge CLK);
        total_n++;
        if ({err_n > 0, wren_n - w0} !== {1'b1, 32'd0})
            $display("FAIL timeout_idle: got writes=%0d expected 0", wren_n - w0);
        else pass_n++;
    endtask
`endif

    initial begin
        total_n = 0; pass_n = 0;
        wren_n = 0; rden_n = 0; aen_n = 0; err_n = 0; rsv_n = 0; asv_n = 0;
        test_reset();
        test_rf_write();
        test_rf_read();
        test_alu_operands();
        test_alu_no_operands();
        test_bad_cmd();
        test_reset_mid_frame();
`ifdef SYS_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
